square_wave_analyzer: RTL and testbench

Downstream consumer of the square-wave generator output. Samples an asynchronous square wave on the system clock and measures its high time, low time and period in clock cycles. Publishes one measurement per full input period, with a single-cycle valid strobe, edge strobes and lock/timeout status. The outputs feed the frequency and duty-cycle checking logic.

---
 rtl/square_wave_analyzer.sv | 166 ++++++++++++++++
 tb/tb_square_wave_analyzer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/square_wave_analyzer.sv
// Measures high time, low time and period of an asynchronous square wave in clk cycles.
// One measurement per full input period, plus edge strobes and lock/timeout status.
module square_wave_analyzer #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   input  logic             enable,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] low_cnt,
   output logic [CNT_W:0]   period,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RISE = 2'd1,
      MEAS_HIGH = 2'd2,
      MEAS_LOW  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [CNT_W-1:0]       hcnt_q, hcnt_d;
   logic [CNT_W-1:0]       lcnt_q, lcnt_d;
   logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
   logic [CNT_W-1:0]       low_cnt_q, low_cnt_d;
   logic [CNT_W:0]         period_q, period_d;
   logic                   rise_pulse_q, rise_pulse_d;
   logic                   fall_pulse_q, fall_pulse_d;
   logic                   meas_valid_q, meas_valid_d;
   logic                   locked_q, locked_d;
   logic                   timeout_q, timeout_d;

   logic s_sync;
   logic rise_cyc;
   logic fall_cyc;

   assign s_sync   = sync_q[SYNC_STAGES-1];
   assign rise_cyc = s_sync & ~prev_q;
   assign fall_cyc = ~s_sync & prev_q;

   always_comb begin
      sync_d       = {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_d       = s_sync;
      state_d      = state_q;
      hcnt_d       = hcnt_q;
      lcnt_d       = lcnt_q;
      high_cnt_d   = high_cnt_q;
      low_cnt_d    = low_cnt_q;
      period_d     = period_q;
      rise_pulse_d = rise_cyc;
      fall_pulse_d = fall_cyc;
      meas_valid_d = 1'b0;
      locked_d     = locked_q;
      timeout_d    = 1'b0;

      // Disable beats saturation, which beats edges; measurement outputs hold.
      if (!enable) begin
         state_d  = IDLE;
         hcnt_d   = '0;
         lcnt_d   = '0;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               hcnt_d  = '0;
               lcnt_d  = '0;
               state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
               if (rise_cyc) begin
                  hcnt_d  = CNT_ONE;
                  state_d = MEAS_HIGH;
               end
            end
            MEAS_HIGH: begin
               if (hcnt_q == CNT_MAX) begin
                  timeout_d = 1'b1;
                  locked_d  = 1'b0;
                  hcnt_d    = '0;
                  lcnt_d    = '0;
                  state_d   = WAIT_RISE;
               end else if (fall_cyc) begin
                  lcnt_d  = CNT_ONE;
                  state_d = MEAS_LOW;
               end else begin
                  hcnt_d = hcnt_q + CNT_ONE;
               end
            end
            MEAS_LOW: begin
               if (lcnt_q == CNT_MAX) begin
                  timeout_d = 1'b1;
                  locked_d  = 1'b0;
                  hcnt_d    = '0;
                  lcnt_d    = '0;
                  state_d   = WAIT_RISE;
               end else if (rise_cyc) begin
                  high_cnt_d   = hcnt_q;
                  low_cnt_d    = lcnt_q;
                  period_d     = {1'b0, hcnt_q} + {1'b0, lcnt_q};
                  meas_valid_d = 1'b1;
                  locked_d     = 1'b1;
                  hcnt_d       = CNT_ONE;
                  state_d      = MEAS_HIGH;
               end else begin
                  lcnt_d = lcnt_q + CNT_ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sync_q       <= '0;
         prev_q       <= 1'b0;
         hcnt_q       <= '0;
         lcnt_q       <= '0;
         high_cnt_q   <= '0;
         low_cnt_q    <= '0;
         period_q     <= '0;
         rise_pulse_q <= 1'b0;
         fall_pulse_q <= 1'b0;
         meas_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         prev_q       <= prev_d;
         hcnt_q       <= hcnt_d;
         lcnt_q       <= lcnt_d;
         high_cnt_q   <= high_cnt_d;
         low_cnt_q    <= low_cnt_d;
         period_q     <= period_d;
         rise_pulse_q <= rise_pulse_d;
         fall_pulse_q <= fall_pulse_d;
         meas_valid_q <= meas_valid_d;
         locked_q     <= locked_d;
         timeout_q    <= timeout_d;
      end
   end

   assign rise_pulse = rise_pulse_q;
   assign fall_pulse = fall_pulse_q;
   assign high_cnt   = high_cnt_q;
   assign low_cnt    = low_cnt_q;
   assign period     = period_q;
   assign meas_valid = meas_valid_q;
   assign locked     = locked_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_square_wave_analyzer.sv
// Scoreboard bench for square_wave_analyzer: a timestamp-based reference model predicts
// per-cycle status and published measurements; a monitor compares on the falling edge.
module tb_square_wave_analyzer;

   localparam int CNT_W = 4;
   localparam int S     = 2;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             sig_in = 1'b0;
   logic             enable = 1'b0;
   logic             rise_pulse;
   logic             fall_pulse;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] low_cnt;
   logic [CNT_W:0]   period;
   logic             meas_valid;
   logic             locked;
   logic             timeout;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   square_wave_analyzer #(.CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
      .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
      .high_cnt(high_cnt), .low_cnt(low_cnt), .period(period),
      .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
   );

   typedef struct {
      bit rp, fp, mv, lk, to;
      int hi, lo, per;
   } exp_t;

   typedef struct {
      int hi, lo, per;
   } meas_t;

   exp_t  cyc_q[$];
   meas_t meas_q[$];

   // Reference model: measurement phases tracked with edge timestamps.
   initial begin : model
      bit   hist [S+1];
      int   phase, t, rise_t, fall_t, hi, lo, per;
      bit   lk, rise, fall;
      exp_t e;
      meas_t m;
      phase = 0; t = 0; rise_t = 0; fall_t = 0; hi = 0; lo = 0; per = 0; lk = 0;
      for (int i = 0; i <= S; i++) hist[i] = 0;
      forever begin
         @(posedge clk);
         e = '{default: 0};
         if (!rst_n) begin
            for (int i = 0; i <= S; i++) hist[i] = 0;
            phase = 0; hi = 0; lo = 0; per = 0; lk = 0;
         end else begin
            rise = hist[S-1] && !hist[S];
            fall = !hist[S-1] && hist[S];
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = sig_in;
            e.rp = rise;
            e.fp = fall;
            if (!enable) begin
               phase = 0;
               lk = 0;
            end else begin
               case (phase)
                  0: phase = 1;
                  1: if (rise) begin phase = 2; rise_t = t; end
                  2: begin
                     if (t - rise_t >= MAXC) begin e.to = 1; lk = 0; phase = 1; end
                     else if (fall) begin fall_t = t; phase = 3; end
                  end
                  default: begin
                     if (t - fall_t >= MAXC) begin e.to = 1; lk = 0; phase = 1; end
                     else if (rise) begin
                        hi = fall_t - rise_t;
                        lo = t - fall_t;
                        per = hi + lo;
                        e.mv = 1;
                        lk = 1;
                        m.hi = hi; m.lo = lo; m.per = per;
                        meas_q.push_back(m);
                        rise_t = t;
                        phase = 2;
                     end
                  end
               endcase
            end
         end
         e.lk = lk; e.hi = hi; e.lo = lo; e.per = per;
         cyc_q.push_back(e);
         t++;
      end
   end

   // Monitor: per-cycle status check plus measurement pop on every meas_valid.
   initial begin : monitor
      exp_t  e;
      meas_t m;
      int    cyc;
      cyc = 0;
      forever begin
         @(negedge clk);
         tests++;
         if (cyc_q.size() == 0) begin
            fails++;
            $display("FAIL status cyc=%0d: no expected entry available", cyc);
         end else begin
            e = cyc_q.pop_front();
            if (rise_pulse !== e.rp || fall_pulse !== e.fp || meas_valid !== e.mv ||
                locked !== e.lk || timeout !== e.to || high_cnt !== CNT_W'(e.hi) ||
                low_cnt !== CNT_W'(e.lo) || period !== (CNT_W+1)'(e.per)) begin
               fails++;
               $display("FAIL status cyc=%0d: got rp=%b fp=%b mv=%b lk=%b to=%b hi=%0d lo=%0d per=%0d, want rp=%b fp=%b mv=%b lk=%b to=%b hi=%0d lo=%0d per=%0d",
                        cyc, rise_pulse, fall_pulse, meas_valid, locked, timeout, high_cnt, low_cnt, period,
                        e.rp, e.fp, e.mv, e.lk, e.to, e.hi, e.lo, e.per);
            end
         end
         if (meas_valid === 1'b1) begin
            tests++;
            if (meas_q.size() == 0) begin
               fails++;
               $display("FAIL meas cyc=%0d: unexpected meas_valid hi=%0d lo=%0d per=%0d", cyc, high_cnt, low_cnt, period);
            end else begin
               m = meas_q.pop_front();
               if (high_cnt !== CNT_W'(m.hi) || low_cnt !== CNT_W'(m.lo) || period !== (CNT_W+1)'(m.per)) begin
                  fails++;
                  $display("FAIL meas cyc=%0d: got hi=%0d lo=%0d per=%0d, want hi=%0d lo=%0d per=%0d",
                           cyc, high_cnt, low_cnt, period, m.hi, m.lo, m.per);
               end else begin
                  $display("[TB] meas cyc=%0d hi=%0d lo=%0d per=%0d", cyc, high_cnt, low_cnt, period);
               end
            end
         end
         cyc++;
      end
   end

   task automatic cyc(input bit s, input bit en, input bit rst);
      sig_in = s;
      enable = en;
      rst_n  = rst;
      @(negedge clk);
   endtask

   task automatic wave(input int hi, input int lo, input int n, input bit en);
      for (int k = 0; k < n; k++) begin
         repeat (hi) cyc(1'b1, en, 1'b1);
         repeat (lo) cyc(1'b0, en, 1'b1);
      end
   endtask

   initial begin : driver
      int h, l;
      bit en;
      repeat (4) cyc(1'b0, 1'b0, 1'b0);
      wave(5, 5, 8, 1'b1);                 // steady 50% wave
      wave(3, 7, 6, 1'b1);                 // 30% duty
      wave(1, 1, 12, 1'b1);                // fastest legal wave
      wave(4, 4, 3, 1'b1);
      repeat (30) cyc(1'b1, 1'b1, 1'b1);   // high-time saturation
      repeat (30) cyc(1'b0, 1'b1, 1'b1);
      wave(4, 4, 4, 1'b1);
      repeat (25) cyc(1'b0, 1'b1, 1'b1);   // low-time saturation
      wave(3, 3, 4, 1'b1);
      // Enable drops on exactly the edge where the closing rise is detected.
      wave(5, 5, 4, 1'b1);
      repeat (S) cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      repeat (5 - S - 1) cyc(1'b1, 1'b1, 1'b1);
      repeat (5) cyc(1'b0, 1'b1, 1'b1);
      wave(5, 5, 4, 1'b1);
      // Reset while measuring the low phase.
      wave(5, 5, 4, 1'b1);
      repeat (4) cyc(1'b0, 1'b1, 1'b1);
      repeat (2) cyc(1'b0, 1'b1, 1'b0);
      repeat (2) cyc(1'b0, 1'b1, 1'b1);
      wave(5, 5, 4, 1'b1);
      for (int k = 0; k < 60; k++) begin
         h  = $urandom_range(1, 17);
         l  = $urandom_range(1, 17);
         en = ($urandom_range(0, 7) != 0);
         wave(h, l, 1, en);
      end
      wave(2, 3, 4, 1'b1);
      repeat (4) cyc(1'b0, 1'b1, 1'b1);
      tests++;
      if (meas_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expected measurements never published, want 0", meas_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
